// File: rtl/streaming_fifo_monitored.sv
// First-word-fall-through AXI-Stream FIFO on a circular buffer of arbitrary depth,
// with programmable almost-full/almost-empty flags and a peak-occupancy monitor.
module streaming_fifo_monitored #(
  parameter int WIDTH     = 96,
  parameter int DEPTH     = 16384,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [WIDTH-1:0] in0_V_V_TDATA,
  input  logic             in0_V_V_TVALID,
  output logic             in0_V_V_TREADY,
  output logic [WIDTH-1:0] out_V_V_TDATA,
  output logic             out_V_V_TVALID,
  input  logic             out_V_V_TREADY,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    max_count,
  input  logic             clear_max,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             push;
  logic             pop;

  // Handshakes depend only on the registered count, so there is no ready-to-ready path.
  assign in0_V_V_TREADY = (count != CW'(DEPTH));
  assign out_V_V_TVALID = (count != '0);
  assign out_V_V_TDATA  = mem[rd_ptr];

  assign push = in0_V_V_TVALID & in0_V_V_TREADY;
  assign pop  = out_V_V_TVALID & out_V_V_TREADY;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (!push && pop)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (push)
      mem[wr_ptr] <= in0_V_V_TDATA;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      max_count    <= '0;
      almost_full  <= (AF_THRESH == 0);
      almost_empty <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count_nxt;
      // Flags come from the next count so they line up with count itself.
      almost_full  <= (count_nxt >= CW'(AF_THRESH));
      almost_empty <= (count_nxt <= CW'(AE_THRESH));
      if (clear_max)
        max_count <= count_nxt;
      else if (count_nxt > max_count)
        max_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_streaming_fifo_monitored.sv
// Directed bench for streaming_fifo_monitored at DEPTH=5, WIDTH=8, AF_THRESH=3, AE_THRESH=1.
module tb_streaming_fifo_monitored;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             ap_clk = 1'b0;
  logic             ap_rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic [CW-1:0]    max_count;
  logic             clear_max;
  logic             almost_full;
  logic             almost_empty;

  int n_cmp = 0;
  int n_err = 0;

  streaming_fifo_monitored #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(3), .AE_THRESH(1)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .in0_V_V_TDATA (in_data),
    .in0_V_V_TVALID(in_valid),
    .in0_V_V_TREADY(in_ready),
    .out_V_V_TDATA (out_data),
    .out_V_V_TVALID(out_valid),
    .out_V_V_TREADY(out_ready),
    .count         (count),
    .max_count     (max_count),
    .clear_max     (clear_max),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] nxt;
  int               max_m;
  bit               v, r, psh, pp;

  initial begin
    ap_rst_n  = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear_max = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    chk("rst_count", count, 0);
    chk("rst_tvalid", out_valid, 0);
    chk("rst_tready", in_ready, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_max", max_count, 0);
    step();

    // Burst fill with downstream stalled
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h11 + 8'(i);
      step();
      chk("fill_count", count, i + 1);
      chk("fill_af", almost_full, (i + 1 >= 3) ? 1 : 0);
      chk("fill_ae", almost_empty, (i + 1 <= 1) ? 1 : 0);
    end
    chk("full_tready", in_ready, 0);
    chk("full_max", max_count, 5);
    in_data = 8'h16;
    step();
    step();
    chk("full_hold_count", count, 5);
    chk("full_head", out_data, 8'h11);
    in_valid = 1'b0;

    // Drain in order
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, 8'h11 + 8'(i));
      step();
      if (i == 0) chk("drain_tready", in_ready, 1);
    end
    out_ready = 1'b0;
    chk("drain_count", count, 0);
    chk("drain_tvalid", out_valid, 0);
    chk("drain_max", max_count, 5);
    chk("drain_ae", almost_empty, 1);

    // Latency and stability under stall
    in_valid = 1'b1;
    in_data  = 8'hA5;
    chk("lat_pre_valid", out_valid, 0);
    step();
    in_valid = 1'b0;
    in_data  = 8'h00;
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 8'hA5);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("lat_pop_count", count, 0);

    // Simultaneous push and pop at count=2
    in_valid = 1'b1;
    in_data  = 8'h21;
    step();
    in_data = 8'h22;
    step();
    chk("conc_pre_count", count, 2);
    in_data   = 8'h23;
    out_ready = 1'b1;
    chk("conc_head", out_data, 8'h21);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("conc_count", count, 2);
    chk("conc_head2", out_data, 8'h22);

    // Random valid/ready against a queue scoreboard
    q.push_back(8'h22);
    q.push_back(8'h23);
    nxt   = 8'h50;
    max_m = 5;
    for (int c = 0; c < 40; c++) begin
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      in_valid  = v;
      in_data   = nxt;
      out_ready = r;
      chk("rnd_count", count, q.size());
      chk("rnd_tvalid", out_valid, (q.size() != 0) ? 1 : 0);
      chk("rnd_tready", in_ready, (q.size() != DEPTH) ? 1 : 0);
      chk("rnd_af", almost_full, (q.size() >= 3) ? 1 : 0);
      chk("rnd_ae", almost_empty, (q.size() <= 1) ? 1 : 0);
      if (q.size() != 0) chk("rnd_data", out_data, q[0]);
      psh = v && (q.size() != DEPTH);
      pp  = r && (q.size() != 0);
      step();
      if (pp) void'(q.pop_front());
      if (psh) begin
        q.push_back(nxt);
        nxt++;
      end
      if (q.size() > max_m) max_m = q.size();
      chk("rnd_max", max_count, max_m);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() != 0; c++) begin
      chk("rnd_drain_data", out_data, q[0]);
      void'(q.pop_front());
      step();
    end
    out_ready = 1'b0;
    chk("rnd_final_count", count, 0);

    // clear_max and asynchronous reset
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'h31 + 8'(i);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    chk("clr_pre_count", count, 3);
    chk("clr_pre_max", max_count, 5);
    clear_max = 1'b1;
    step();
    clear_max = 1'b0;
    chk("clr_max", max_count, 3);
    chk("clr_count", count, 3);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_max", max_count, 0);
    chk("arst_tvalid", out_valid, 0);
    chk("arst_tready", in_ready, 1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h41;
    step();
    in_data = 8'h42;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("post_rst_first", out_data, 8'h41);
    step();
    chk("post_rst_second", out_data, 8'h42);
    step();
    out_ready = 1'b0;
    chk("post_rst_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/streaming_fifo_monitored.md
Name: streaming_fifo_monitored

Overview:
- Parametrised AXI-Stream FIFO for dataflow accelerator pipelines. It is the next generation of the fixed-geometry shift-register FIFOs placed between compute layers.
- Adds three things the fixed FIFOs lack:
  - arbitrary (non-power-of-2) depth;
  - almost-full and almost-empty flags with programmable thresholds;
  - a peak-occupancy (high-water) monitor, so FIFO depths can be sized from rtlsim/hardware runs.
- Storage is a circular buffer with asynchronous read (LUTRAM/SRL inferable). Output is first-word-fall-through.

Parameters:
- WIDTH, 96, data width in bits (>=1).
- DEPTH, 16384, capacity in words (>=2, any integer).
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).
- CW, $clog2(DEPTH+1), derived (localparam): count width.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- in0_V_V_TDATA  in  WIDTH  input stream data.
- in0_V_V_TVALID  in  1  input valid.
- in0_V_V_TREADY  out  1  input ready.
- out_V_V_TDATA  out  WIDTH  output stream data.
- out_V_V_TVALID  out  1  output valid.
- out_V_V_TREADY  in  1  downstream ready.
- count  out  CW  current occupancy.
- max_count  out  CW  peak occupancy since reset or the last clear.
- clear_max  in  1  synchronous pulse; reloads max_count.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.

Behaviour:
- Reset (asynchronous, ap_rst_n=0):
  - wr_ptr=0, rd_ptr=0, count=0, max_count=0.
  - in0_V_V_TREADY=1, out_V_V_TVALID=0, almost_full=(AF_THRESH==0 ? 1 : 0), almost_empty=1.
  - Memory contents are not reset.
- push = in0_V_V_TVALID & in0_V_V_TREADY.
- pop = out_V_V_TVALID & out_V_V_TREADY.
- in0_V_V_TREADY = (count != DEPTH).
  - Derived from registered count only.
  - No combinational path from out_V_V_TREADY.
- out_V_V_TVALID = (count != 0).
- out_V_V_TDATA = mem[rd_ptr] (asynchronous read). Its value is don't-care while TVALID=0.
- Latency: a word pushed at edge N is presented with TVALID=1 in the cycle after edge N. There is no same-cycle bypass.
- On push: mem[wr_ptr] <= TDATA; wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1.
- On pop: rd_ptr wraps the same way.
- count <= count + push - pop:
  - push & pop → unchanged;
  - simultaneous push+pop is legal at any 0 < count < DEPTH.
- Full (count==DEPTH): TREADY=0, so no push.
  - A pop at edge N raises TREADY in the cycle after edge N.
- Empty (count==0): TVALID=0, so no pop. A concurrent push is stored normally.
- AXI rule: once out_V_V_TVALID=1, TVALID and TDATA stay stable until pop. This holds inherently because rd_ptr only moves on pop.
- almost_full / almost_empty are registered, computed from the next count value. They are therefore coincident with count, with no extra lag.
- max_count:
  - If clear_max=1 at an edge, max_count <= next count.
  - Else if next count > max_count, max_count <= next count.
  - It never exceeds DEPTH.
- No internal state machine beyond pointers and counters. Illegal conditions (overflow, underflow) are unreachable by construction.
- Reset mid-operation: all buffered words are discarded and the block returns to the reset state immediately, without waiting for a clock edge.

Test Plan:
- Reset then idle, DEPTH=5, WIDTH=8:
  - count=0, TVALID=0, TREADY=1, almost_empty=1, max_count=0.
  - out data ignored.
- Burst fill, DEPTH=5, out TREADY=0, push 0x11..0x15 on consecutive cycles:
  - TREADY drops in the cycle after the 5th push;
  - count=5, max_count=5, almost_full=1 (AF_THRESH=3 from count=3 onward);
  - a 6th word held on the input is not accepted.
- Drain in order after fill, out TREADY=1:
  - outputs 0x11,0x12,0x13,0x14,0x15 on 5 consecutive cycles;
  - TREADY=1 the cycle after the first pop;
  - count returns to 0, max_count stays 5.
- Wrap and concurrency, DEPTH=5:
  - 40 cycles, random valid/ready at 50%, incrementing data;
  - scoreboard exact order, no loss or duplication;
  - pointers wrap several times;
  - with both handshakes firing at count=2, count stays 2.
- Latency check:
  - single push at edge N into an empty FIFO → TVALID=1 in the cycle after N, TDATA equal to the pushed value;
  - TVALID and TDATA held stable over 3 stalled cycles.
- clear_max and asynchronous reset:
  - at count=3 with max_count=5, pulse clear_max → max_count=3;
  - then assert ap_rst_n=0 between edges → count, max_count, TVALID go to 0 immediately;
  - after release, the first pushed word emerges first.
